// File: rtl/smachine_loader_pkg.sv
// Shared types and constants for the S-Machine program loader.
package smachine_loader_pkg;

   localparam int LD_ADDR_W = 8;    // instruction memory address width (8-bit PC)
   localparam int LD_INST_W = 16;   // instruction width
   localparam int LD_WCNT_W = 9;    // word counter holds 1..256

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_HI,
      S_LO,
      S_WR,
      S_RUN,
      S_DONE
   } state_e;

   // A header byte of 0 stands for a full 256-word image.
   function automatic logic [LD_WCNT_W-1:0] hdr_words(input logic [7:0] b);
      return (b == 8'd0) ? 9'd256 : {1'b0, b};
   endfunction

endpackage

// File: rtl/smachine_loader_if.sv
// Host byte link: valid/ready stream of program bytes into the loader.
interface smachine_loader_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;

   modport master (output rx_valid, output rx_data, input rx_ready);
   modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/smachine_run_timer.sv
// Run-phase timer: cycle counter with saturation plus stop_count compare.
module smachine_run_timer #(
   parameter int RUN_LIMIT = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       latch,        // start accepted: capture stop_in
   input  logic [7:0] stop_in,
   input  logic       run,          // loader is in RUN
   input  logic [7:0] count,
   output logic       hit_target,
   output logic       hit_limit
);

   localparam int CNT_W = (RUN_LIMIT > 1) ? $clog2(RUN_LIMIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(RUN_LIMIT - 1);

   logic [7:0]       stop_q, stop_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter runs only in RUN and parks at LAST; it restarts from 0 each run.
   always_comb begin
      stop_d = latch ? stop_in : stop_q;
      cnt_d  = '0;
      if (run) cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stop_q <= '0;
         cnt_q  <= '0;
      end else begin
         stop_q <= stop_d;
         cnt_q  <= cnt_d;
      end
   end

   assign hit_target = (stop_q != 8'd0) && (count == stop_q);
   assign hit_limit  = (cnt_q == LAST);

endmodule

// File: rtl/smachine_loader.sv
// Program-load and run controller in front of the S-Machine.
module smachine_loader
   import smachine_loader_pkg::*;
#(
   parameter int ADDR_W    = LD_ADDR_W,
   parameter int INST_W    = LD_INST_W,
   parameter int RUN_LIMIT = 1000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [7:0]         stop_count,
   smachine_loader_if.slave   rx,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INST_W-1:0]  imem_wdata,
   output logic               enable,
   input  logic [7:0]         count,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic               error
);

   state_e               state_q, state_d;
   logic [LD_WCNT_W-1:0] n_q, n_d, wcnt_q, wcnt_d;
   logic [7:0]           hi_q, hi_d, lo_q, lo_d;
   logic                 rx_ready_q, rx_ready_d;
   logic                 timeout_q, timeout_d, error_q, error_d;
   logic                 xfer, start_go, hit_target, hit_limit;

   assign xfer     = rx.rx_valid && rx_ready_q;
   // Abort suppresses a coincident start.
   assign start_go = (state_q == S_IDLE || state_q == S_DONE) && start && !abort;

   smachine_run_timer #(.RUN_LIMIT(RUN_LIMIT)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .latch      (start_go),
      .stop_in    (stop_count),
      .run        (state_q == S_RUN),
      .count      (count),
      .hit_target (hit_target),
      .hit_limit  (hit_limit)
   );

   // Next-state logic: load header, hi/lo bytes, write, then run until an exit.
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      wcnt_d    = wcnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      timeout_d = timeout_q;
      error_d   = error_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_go) begin
               state_d   = S_HDR;
               timeout_d = 1'b0;
               error_d   = 1'b0;
            end
         end
         S_HDR, S_HI, S_LO, S_WR: begin
            if (abort) begin
               state_d = S_IDLE;
               error_d = 1'b1;
            end else if (state_q == S_WR) begin
               wcnt_d  = wcnt_q + 9'd1;
               state_d = (wcnt_q == n_q - 9'd1) ? S_RUN : S_HI;
            end else if (xfer) begin
               case (state_q)
                  S_HDR: begin
                     n_d     = hdr_words(rx.rx_data);
                     wcnt_d  = '0;
                     state_d = S_HI;
                  end
                  S_HI: begin
                     hi_d    = rx.rx_data;
                     state_d = S_LO;
                  end
                  default: begin
                     lo_d    = rx.rx_data;
                     state_d = S_WR;
                  end
               endcase
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_DONE;
               error_d = 1'b1;
            end else if (hit_target) begin
               state_d = S_DONE;
            end else if (hit_limit) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      rx_ready_d = (state_d == S_HDR) || (state_d == S_HI) || (state_d == S_LO);
   end

   // State registers; reset discards any load or run in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         wcnt_q     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         rx_ready_q <= 1'b0;
         timeout_q  <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         wcnt_q     <= wcnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         rx_ready_q <= rx_ready_d;
         timeout_q  <= timeout_d;
         error_q    <= error_d;
      end
   end

   assign rx.rx_ready = rx_ready_q;
   // An abort landing in the WR cycle must not leave a stray write behind.
   assign imem_we     = (state_q == S_WR) && !abort;
   assign imem_addr   = ADDR_W'(wcnt_q);
   assign imem_wdata  = INST_W'({hi_q, lo_q});
   assign enable      = (state_q == S_RUN);
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done        = (state_q == S_DONE);
   assign timeout     = timeout_q;
   assign error       = error_q;

endmodule
